// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared constants for the 5-stage pipeline controller.
//   NREG   : number of GPRs; register 0 is hard-wired and never tracked
//   CNT_W  : scoreboard counter width; at most 3 writes are in flight
//            (one each in EXE, MEM and WB), so 2 bits are sufficient
//   REG_W  : width of a GPR number
//   ST_*   : stage indices into the per-stage valid vector
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam int NREG   = 32;
    localparam int CNT_W  = 2;
    localparam int REG_W  = 5;
    localparam int NSTAGE = 5;

    localparam int ST_IF  = 0;
    localparam int ST_ID  = 1;
    localparam int ST_EXE = 2;
    localparam int ST_MEM = 3;
    localparam int ST_WB  = 4;

endpackage

// File: rtl/pipe_ctrl_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
// Per-GPR count of writes that have left decode but not yet committed at WB.
// A non-zero count means the register value in the register file is stale.
//
// Ports
//   clk, rst     clock / asynchronous active-high reset
//   clear_i      zero every counter (pipeline flush); wins over inc/dec
//   inc_i        a writer to inc_reg_i issues this cycle
//   inc_reg_i    destination of the issuing writer
//   dec_i        a writer to dec_reg_i commits this cycle
//   dec_reg_i    destination of the committing writer
//   rd0_reg_i    lookup port 0 register number
//   rd0_busy_o   rd0_reg_i has a write in flight (combinational)
//   rd1_reg_i    lookup port 1 register number
//   rd1_busy_o   rd1_reg_i has a write in flight (combinational)
// ---------------------------------------------------------------------------
module reg_scoreboard
    import pipe_ctrl_pkg::*;
#(
    parameter int N_REG = NREG,
    parameter int C_W   = CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             inc_i,
    input  logic [REG_W-1:0] inc_reg_i,
    input  logic             dec_i,
    input  logic [REG_W-1:0] dec_reg_i,
    input  logic [REG_W-1:0] rd0_reg_i,
    output logic             rd0_busy_o,
    input  logic [REG_W-1:0] rd1_reg_i,
    output logic             rd1_busy_o
);

    logic [C_W-1:0] cnt [N_REG];

    // Register 0 is never written, so it never has anything in flight.
    assign cnt[0] = '0;

    for (genvar gi = 1; gi < N_REG; gi++) begin : g_cnt
        logic           inc_hit;
        logic           dec_hit;
        logic [C_W-1:0] cnt_q;
        logic [C_W-1:0] cnt_d;

        assign inc_hit = inc_i && (inc_reg_i == REG_W'(gi));
        assign dec_hit = dec_i && (dec_reg_i == REG_W'(gi));

        // Simultaneous issue and commit on the same register cancel out.
        always_comb begin
            cnt_d = cnt_q;
            if (clear_i) begin
                cnt_d = '0;
            end else if (inc_hit && !dec_hit) begin
                cnt_d = cnt_q + C_W'(1);
            end else if (dec_hit && !inc_hit) begin
                cnt_d = cnt_q - C_W'(1);
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign cnt[gi] = cnt_q;

        // The counter is deliberately not saturated: pipeline depth bounds it,
        // so reaching either end means the pipeline itself is broken.
        a_no_overflow: assert property (@(posedge clk) disable iff (rst)
            !(!clear_i && inc_hit && !dec_hit && (cnt_q == {C_W{1'b1}})));
        a_no_underflow: assert property (@(posedge clk) disable iff (rst)
            !(!clear_i && dec_hit && !inc_hit && (cnt_q == '0)));
    end

    assign rd0_busy_o = (cnt[rd0_reg_i] != '0);
    assign rd1_busy_o = (cnt[rd1_reg_i] != '0);

endmodule

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
// Central sequencer of the IF/ID/EXE/MEM/WB pipeline. Owns the stage valid
// bits, the allow_in back-pressure chain, the bus-register load enables, the
// RAW scoreboard feeding decode, and the WB-level exception/ERET flush.
//
// Ports
//   clk, rst                   clock / asynchronous active-high reset
//   IF_over..WB_over           stage finished its instruction this cycle
//   exc_flush                  WB commits SYSCALL/ERET; squashes ID..WB
//   id_rs, id_rt               decode source register numbers
//   id_rs_used, id_rt_used     decode actually reads that source
//   id_wen, id_wdest           decode instruction writes a GPR / which one
//   wb_wen, wb_wdest           WB instruction writes a GPR / which one
//   IF_valid..WB_valid         stage holds a live instruction
//   IF_ID_en..MEM_WB_en        load the corresponding inter-stage bus register
//   rs_wait, rt_wait           decode source has a write in flight
//   perf_stall                 cycles decode held a live, unfinished instruction
//   perf_retire                instructions completed at WB
//   perf_flush                 flush events
//
// Build option: define PIPE_PERF_EN to implement the three 32-bit wrapping
// perf counters (cleared only by rst). Without it the perf_* outputs are 0.
// ---------------------------------------------------------------------------
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             IF_over,
    input  logic             ID_over,
    input  logic             EXE_over,
    input  logic             MEM_over,
    input  logic             WB_over,
    input  logic             exc_flush,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic             id_wen,
    input  logic [REG_W-1:0] id_wdest,
    input  logic             wb_wen,
    input  logic [REG_W-1:0] wb_wdest,
    output logic             IF_valid,
    output logic             ID_valid,
    output logic             EXE_valid,
    output logic             MEM_valid,
    output logic             WB_valid,
    output logic             IF_ID_en,
    output logic             ID_EXE_en,
    output logic             EXE_MEM_en,
    output logic             MEM_WB_en,
    output logic             rs_wait,
    output logic             rt_wait,
    output logic [31:0]      perf_stall,
    output logic [31:0]      perf_retire,
    output logic [31:0]      perf_flush
);

    logic [NSTAGE-1:0] valid_q;
    logic [NSTAGE-1:0] valid_d;

    logic id_allow_in;
    logic exe_allow_in;
    logic mem_allow_in;
    logic wb_allow_in;

    logic sb_inc;
    logic sb_dec;
    logic rs_busy;
    logic rt_busy;
    logic wb_done;

    assign IF_valid  = valid_q[ST_IF];
    assign ID_valid  = valid_q[ST_ID];
    assign EXE_valid = valid_q[ST_EXE];
    assign MEM_valid = valid_q[ST_MEM];
    assign WB_valid  = valid_q[ST_WB];

    // A stage can accept a new instruction when it is empty, or when its
    // current instruction is leaving this very cycle. The chain is evaluated
    // from WB backwards so a stall anywhere freezes everything before it.
    assign wb_allow_in  = ~valid_q[ST_WB]  | WB_over;
    assign mem_allow_in = ~valid_q[ST_MEM] | (MEM_over & wb_allow_in);
    assign exe_allow_in = ~valid_q[ST_EXE] | (EXE_over & mem_allow_in);
    assign id_allow_in  = ~valid_q[ST_ID]  | (ID_over  & exe_allow_in);

    assign IF_ID_en   = valid_q[ST_IF]  & IF_over  & id_allow_in  & ~exc_flush;
    assign ID_EXE_en  = valid_q[ST_ID]  & ID_over  & exe_allow_in & ~exc_flush;
    assign EXE_MEM_en = valid_q[ST_EXE] & EXE_over & mem_allow_in & ~exc_flush;
    assign MEM_WB_en  = valid_q[ST_MEM] & MEM_over & wb_allow_in  & ~exc_flush;

    assign wb_done = valid_q[ST_WB] & WB_over;

    // IF always has a fetch in progress once out of reset; a flush squashes
    // everything downstream and redirects IF without invalidating it.
    always_comb begin
        valid_d        = valid_q;
        valid_d[ST_IF] = 1'b1;
        if (exc_flush) begin
            valid_d[ST_WB:ST_ID] = '0;
        end else begin
            if (id_allow_in)  valid_d[ST_ID]  = IF_ID_en;
            if (exe_allow_in) valid_d[ST_EXE] = ID_EXE_en;
            if (mem_allow_in) valid_d[ST_MEM] = EXE_MEM_en;
            if (wb_allow_in)  valid_d[ST_WB]  = MEM_WB_en;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // A write is in flight from the edge it leaves decode until the edge it
    // commits at WB; the consumer may read the register file the cycle after.
    assign sb_inc = ID_EXE_en & id_wen & (id_wdest != '0);
    assign sb_dec = wb_done & wb_wen & (wb_wdest != '0);

    reg_scoreboard #(
        .N_REG (NREG),
        .C_W   (CNT_W)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (exc_flush),
        .inc_i      (sb_inc),
        .inc_reg_i  (id_wdest),
        .dec_i      (sb_dec),
        .dec_reg_i  (wb_wdest),
        .rd0_reg_i  (id_rs),
        .rd0_busy_o (rs_busy),
        .rd1_reg_i  (id_rt),
        .rd1_busy_o (rt_busy)
    );

    // Register 0 is never busy in the scoreboard, so no explicit $0 test.
    assign rs_wait = id_rs_used & rs_busy;
    assign rt_wait = id_rt_used & rt_busy;

    a_flush_at_commit: assert property (@(posedge clk) disable iff (rst)
        exc_flush |-> (valid_q[ST_WB] && WB_over));

`ifdef PIPE_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_stall_d;
    logic [31:0] perf_retire_q;
    logic [31:0] perf_retire_d;
    logic [31:0] perf_flush_q;
    logic [31:0] perf_flush_d;

    always_comb begin
        perf_stall_d  = perf_stall_q  + {31'd0, (valid_q[ST_ID] & ~ID_over)};
        perf_retire_d = perf_retire_q + {31'd0, wb_done};
        perf_flush_d  = perf_flush_q  + {31'd0, exc_flush};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_q  <= '0;
            perf_retire_q <= '0;
            perf_flush_q  <= '0;
        end else begin
            perf_stall_q  <= perf_stall_d;
            perf_retire_q <= perf_retire_d;
            perf_flush_q  <= perf_flush_d;
        end
    end

    assign perf_stall  = perf_stall_q;
    assign perf_retire = perf_retire_q;
    assign perf_flush  = perf_flush_q;
`else
    assign perf_stall  = 32'd0;
    assign perf_retire = 32'd0;
    assign perf_flush  = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl
// Randomized bench for pipe_ctrl. The reference keeps the actual instructions
// occupying each stage; the RAW expectation is derived by searching EXE/MEM/WB
// for an uncommitted writer of the source register.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        IF_over, ID_over, EXE_over, MEM_over, WB_over;
    logic        exc_flush;
    logic [4:0]  id_rs, id_rt, id_wdest, wb_wdest;
    logic        id_rs_used, id_rt_used, id_wen, wb_wen;
    logic        IF_valid, ID_valid, EXE_valid, MEM_valid, WB_valid;
    logic        IF_ID_en, ID_EXE_en, EXE_MEM_en, MEM_WB_en;
    logic        rs_wait, rt_wait;
    logic [31:0] perf_stall, perf_retire, perf_flush;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .IF_over     (IF_over),
        .ID_over     (ID_over),
        .EXE_over    (EXE_over),
        .MEM_over    (MEM_over),
        .WB_over     (WB_over),
        .exc_flush   (exc_flush),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rs_used  (id_rs_used),
        .id_rt_used  (id_rt_used),
        .id_wen      (id_wen),
        .id_wdest    (id_wdest),
        .wb_wen      (wb_wen),
        .wb_wdest    (wb_wdest),
        .IF_valid    (IF_valid),
        .ID_valid    (ID_valid),
        .EXE_valid   (EXE_valid),
        .MEM_valid   (MEM_valid),
        .WB_valid    (WB_valid),
        .IF_ID_en    (IF_ID_en),
        .ID_EXE_en   (ID_EXE_en),
        .EXE_MEM_en  (EXE_MEM_en),
        .MEM_WB_en   (MEM_WB_en),
        .rs_wait     (rs_wait),
        .rt_wait     (rt_wait),
        .perf_stall  (perf_stall),
        .perf_retire (perf_retire),
        .perf_flush  (perf_flush)
    );

    typedef struct packed {
        logic        v;
        logic [31:0] seq;
        logic        wen;
        logic [4:0]  wdest;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        rs_used;
        logic        rt_used;
    } ins_t;

    ins_t        st [NSTAGE];
    int unsigned next_seq;
    int unsigned errors;
    int unsigned checks;
    logic [31:0] m_stall, m_retire, m_flush;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Small register range so hazards and same-register issue/commit are common.
    task automatic fetch_new(output ins_t i);
        i.v       = 1'b1;
        i.seq     = next_seq;
        next_seq++;
        i.wen     = 1'($urandom_range(0, 1));
        i.wdest   = 5'($urandom_range(0, 7));
        i.rs      = 5'($urandom_range(0, 7));
        i.rt      = 5'($urandom_range(0, 7));
        i.rs_used = 1'($urandom_range(0, 1));
        i.rt_used = 1'($urandom_range(0, 1));
    endtask

    // A register is pending while some issued, uncommitted instruction writes it.
    function automatic logic pending(input logic [4:0] r);
        logic p;
        p = 1'b0;
        for (int s = ST_EXE; s <= ST_WB; s++) begin
            if (st[s].v && st[s].wen && (st[s].wdest == r)) p = 1'b1;
        end
        return p && (r != 5'd0);
    endfunction

    task automatic model_reset();
        for (int s = 0; s < NSTAGE; s++) st[s] = '0;
        m_stall  = '0;
        m_retire = '0;
        m_flush  = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_valid"}, 32'({WB_valid, MEM_valid, EXE_valid, ID_valid, IF_valid}), 32'd0);
        check_val({tag, "_en"}, 32'({MEM_WB_en, EXE_MEM_en, ID_EXE_en, IF_ID_en}), 32'd0);
        check_val({tag, "_wait"}, 32'({rs_wait, rt_wait}), 32'd0);
        check_val({tag, "_perf"}, perf_stall | perf_retire | perf_flush, 32'd0);
    endtask

    task automatic run_cycle(input int over_pct, input int flush_pct);
        logic [4:0] ov;
        logic [4:0] exp_valid;
        logic [3:0] exp_en;
        logic       fr [NSTAGE];
        logic       mv [NSTAGE-1];
        logic       ers, ert;

        @(negedge clk);
        for (int s = 0; s < NSTAGE; s++) ov[s] = ($urandom_range(0, 99) < over_pct);

        if (st[ST_ID].v) begin
            id_rs = st[ST_ID].rs;  id_rt = st[ST_ID].rt;
            id_rs_used = st[ST_ID].rs_used;  id_rt_used = st[ST_ID].rt_used;
            id_wen = st[ST_ID].wen;  id_wdest = st[ST_ID].wdest;
        end else begin
            id_rs = 5'($urandom_range(0, 7));  id_rt = 5'($urandom_range(0, 7));
            id_rs_used = 1'($urandom_range(0, 1));  id_rt_used = 1'($urandom_range(0, 1));
            id_wen = 1'($urandom_range(0, 1));  id_wdest = 5'($urandom_range(0, 7));
        end
        ers = id_rs_used && pending(id_rs);
        ert = id_rt_used && pending(id_rt);
        // Decode cannot finish while a source is outstanding.
        ov[ST_ID] = ov[ST_ID] && !ers && !ert;

        if (st[ST_WB].v) begin
            wb_wen = st[ST_WB].wen;  wb_wdest = st[ST_WB].wdest;
        end else begin
            wb_wen = 1'($urandom_range(0, 1));  wb_wdest = 5'($urandom_range(0, 7));
        end
        // Only a non-writing instruction completing at WB may raise a flush.
        exc_flush = st[ST_WB].v && ov[ST_WB] && !st[ST_WB].wen && ($urandom_range(0, 99) < flush_pct);
        {WB_over, MEM_over, EXE_over, ID_over, IF_over} = ov;
        #1;

        // A stage is free for the next cycle if empty or its occupant moves on.
        fr[ST_WB] = !st[ST_WB].v || ov[ST_WB];
        for (int s = ST_MEM; s >= ST_IF; s--) fr[s] = !st[s].v || (ov[s] && fr[s+1]);
        for (int s = 0; s < NSTAGE - 1; s++) begin
            mv[s]     = st[s].v && ov[s] && fr[s+1] && !exc_flush;
            exp_en[s] = mv[s];
        end
        for (int s = 0; s < NSTAGE; s++) exp_valid[s] = st[s].v;

        check_val("valid", 32'({WB_valid, MEM_valid, EXE_valid, ID_valid, IF_valid}), 32'(exp_valid));
        check_val("en", 32'({MEM_WB_en, EXE_MEM_en, ID_EXE_en, IF_ID_en}), 32'(exp_en));
        check_val("rs_wait", 32'(rs_wait), 32'(ers));
        check_val("rt_wait", 32'(rt_wait), 32'(ert));
`ifdef PIPE_PERF_EN
        check_val("perf_stall", perf_stall, m_stall);
        check_val("perf_retire", perf_retire, m_retire);
        check_val("perf_flush", perf_flush, m_flush);
`else
        check_val("perf_tied", perf_stall | perf_retire | perf_flush, 32'd0);
`endif

        if (st[ST_ID].v && !ov[ST_ID]) m_stall++;
        if (st[ST_WB].v && ov[ST_WB]) begin
            m_retire++;
            $display("retire seq=%0d wen=%0d wdest=%0d flush=%0d", st[ST_WB].seq, st[ST_WB].wen,
                     st[ST_WB].wdest, exc_flush);
        end
        if (exc_flush) m_flush++;

        if (exc_flush) begin
            for (int s = ST_ID; s <= ST_WB; s++) st[s] = '0;
        end else begin
            for (int y = ST_WB; y >= ST_ID; y--) begin
                if (fr[y]) st[y] = mv[y-1] ? st[y-1] : '0;
            end
        end
        if (mv[ST_IF] || !st[ST_IF].v) fetch_new(st[ST_IF]);
    endtask

    initial begin
        rst = 1'b1;
        {IF_over, ID_over, EXE_over, MEM_over, WB_over, exc_flush} = '0;
        {id_rs, id_rt, id_wdest, wb_wdest} = '0;
        {id_rs_used, id_rt_used, id_wen, wb_wen} = '0;
        errors   = 0;
        checks   = 0;
        next_seq = 0;
        model_reset();

        repeat (3) begin
            @(negedge clk);
            #1;
            check_all_zero("reset");
        end
        @(posedge clk);
        #2;
        rst = 1'b0;

        repeat (300)  run_cycle(100, 0);
        repeat (1500) run_cycle(75, 4);

        // Reset in the middle of traffic, asynchronously between edges.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;

        repeat (300) run_cycle(60, 8);
        repeat (300) run_cycle(100, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
